// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH    = 4;
  localparam int MULT_ITERS    = 4;
  localparam int PRODUCT_WIDTH = 8;

endpackage

// File: rtl/seq_mult_ctrl_rca.sv
// 4-bit ripple-carry adder shared by every iteration of the multiplier.
module RippleCarryFA
  import mult_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] a,
  input  logic [MULT_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [MULT_WIDTH-1:0] sum,
  output logic                  cout
);

  logic [MULT_WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < MULT_WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[MULT_WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shared adder, four add/shift
// iterations, 8-bit product with a one-cycle done pulse.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [PRODUCT_WIDTH-1:0] product
);

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             c;
  logic [1:0]       cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Only the multiplier LSB decides whether M is added this iteration.
  assign addend = q[0] ? m : '0;

  RippleCarryFA u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (c),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      c       <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            state <= CALC;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          // Carry, sum and multiplier shift right together as one register.
          c   <= 1'b0;
          acc <= {cout, sum[WIDTH-1:1]};
          q   <= {sum[0], q[WIDTH-1:1]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'(MULT_ITERS - 1)) begin
            product <= {cout, sum, q[WIDTH-1:1]};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequential 4x4 unsigned shift-and-add multiplier controller for the Multiplier block. It accepts an operand pair via a start/ready handshake and sequences a single shared 4-bit ripple-carry adder over four iterations. It returns an 8-bit product with a one-cycle done pulse. It replaces a combinational array multiplier where area matters more than latency.

## Interface
- WIDTH, 4, operand width; only 4 is supported because it matches the shared 4-bit adder.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- a  in  4  multiplicand (M); captured on accept.
- b  in  4  multiplier (Q); captured on accept.
- ready  out  1  high in IDLE only.
- busy  out  1  high in CALC only.
- done  out  1  one-cycle pulse; product is valid in that cycle.
- product  out  8  result register; holds its value until the next result is written.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on start.
  - CALC -> DONE when cnt==3.
  - DONE -> IDLE unconditionally.
- Datapath registers:
  - M[3:0]: multiplicand.
  - Acc[3:0]: partial product, high half.
  - Q[3:0]: multiplier, shifting into the low half.
  - C: adder carry.
  - cnt[1:0]: iteration counter.
- Accept (IDLE, start=1): M<=a, Q<=b, Acc<=0, C<=0, cnt<=0.
- Each CALC cycle:
  - Sum phase: if Q[0]=1 then {C,Acc} = Acc + M (adder cout goes to C, sum to Acc); else {C,Acc} = {0,Acc}.
  - Shift phase: {C,Acc,Q} <= {0, C, Acc, Q[3:1]}, using the sum-phase values in the same cycle.
  - cnt <= cnt+1.
- Final CALC cycle: product <= {Acc,Q} after the shift. Width rule: the result always fits in 8 bits (max 15*15 = 225), so there is no overflow.
- Inputs a and b are ignored outside the accept edge. Mid-operation operand changes have no effect.
- start in CALC or DONE is ignored, not queued. A start that is still held in the next IDLE cycle is accepted then.
- Reset (any state, including mid-CALC) aborts the operation.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0x00, cnt=0, Acc=0, Q=0, M=0, C=0.
- Cycle numbering: start sampled high at the end of cycle 0.
  - Cycles 1-4: CALC, busy=1, ready=0.
  - Cycle 5: DONE, done=1, product valid.
  - Cycle 6: IDLE, ready=1.
- Latency is 5 cycles from accept to done. Minimum issue interval is 6 cycles, the rate when start is held high continuously.
- product changes only at the end of cycle 4. It is stable from cycle 5 until the next result, through IDLE and through the next CALC.
- All outputs are registered or decoded from the state register only. No combinational path runs from start, a or b to any output.
- Adder path is one ripple-carry add plus a mux per cycle; this sets the critical path.
- rst=1 on any edge: the next cycle is IDLE with reset values, including product=0x00. No done pulse is emitted for an aborted operation.

## Structure
- Shared package mult_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - MULT_WIDTH=4;
  - MULT_ITERS=4;
  - PRODUCT_WIDTH=8.
- One sub-module: the existing 4-bit RippleCarryFA, instantiated once with a=Acc, b=(Q[0] ? M : 4'b0). Its cout becomes C.
- FSM, counter and shift register live in seq_mult_ctrl itself. No further hierarchy.

## Test plan
- Reset, then a=15, b=15, start for 1 cycle -> busy in cycles 1-4, done=1 and product=0xE1 (225) in cycle 5, ready=1 in cycle 6.
- a=9, b=6 -> product=0x36 (54). Then a=0, b=13 -> product=0x00. Then a=13, b=1 -> 0x0D. Confirm product holds 0x36 during the second operation's CALC cycles.
- start held high with a=3, b=5 -> accepts in cycles 0 and 6, done pulses in cycles 5 and 11, product=0x0F each time.
- a=7, b=7 accepted; in cycle 2 drive start=1, a=15, b=15 -> ignored, and the result is 0x31 (49).
- a=15, b=15 accepted; assert rst in cycle 2 -> cycle 3 shows IDLE, ready=1, busy=0, product=0x00, and no done pulse follows.
- Exhaustive: all 256 (a,b) pairs back-to-back -> product == a*b, and exactly one done pulse per accept, 5 cycles after it.
